// File: rtl/pong_pkg.sv
// Shared command byte values and transmitter state type for the pong paddle link.
package pong_pkg;

  localparam logic [7:0] CMD_BOT_STOP = 8'h74;
  localparam logic [7:0] CMD_BOT_L    = 8'h62;
  localparam logic [7:0] CMD_BOT_R    = 8'h65;
  localparam logic [7:0] CMD_TOP_STOP = 8'h6C;
  localparam logic [7:0] CMD_TOP_L    = 8'h6B;
  localparam logic [7:0] CMD_TOP_R    = 8'h6D;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  // One button of a pair held alone selects its move code; none or both means stop.
  function automatic logic [7:0] pair_code(input logic       left,
                                           input logic       right,
                                           input logic [7:0] code_l,
                                           input logic [7:0] code_r,
                                           input logic [7:0] code_stop);
    if (left && !right) return code_l;
    if (right && !left) return code_r;
    return code_stop;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer. Bit timing uses a down-counter that reloads DIV-1 and ends a
// bit on terminal count zero. The line is registered from the current state,
// so it lags the state register by one clock.
//
// state    | meaning
// ---------+------------------------------------------------
// TX_IDLE  | line high, waiting for valid
// TX_START | start bit (low) for DIV cycles
// TX_DATA  | 8 data bits, LSB first, DIV cycles each
// TX_STOP  | stop bit (high); may chain straight into START
module uart_tx_core
  import pong_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       valid,
  output logic       ready,
  output logic       active,
  output logic       tx
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

  uart_tx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     data_q, data_d;
  logic           tx_q, tx_d;
  logic           bit_done;

  assign bit_done = (cnt_q == '0);
  // A byte is accepted from idle, or at the very end of a stop bit so frames chain without a gap.
  assign ready    = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_done);
  assign active   = (state_q != TX_IDLE);
  assign tx       = tx_q;

  // Next-state, bit counter and byte capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    case (state_q)
      TX_IDLE: begin
        if (valid) begin
          data_d  = tx_byte;
          cnt_d   = CNT_LOAD;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          cnt_d   = CNT_LOAD;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          cnt_d = CNT_LOAD;
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          if (valid) begin
            data_d  = tx_byte;
            cnt_d   = CNT_LOAD;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level for the bit currently being timed.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = data_q[bit_q];
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/paddle_cmd_tx.sv
// Paddle buttons -> synchronizer -> change-driven command encoder -> byte FIFO -> UART.
module paddle_cmd_tx
  import pong_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bottom_button_l,
  input  logic bottom_button_r,
  input  logic top_button_l,
  input  logic top_button_r,
  output logic RsTx,
  output logic busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [7:0]  last_bot_q, last_bot_d, last_top_q, last_top_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  bot_code, top_code, push_data, head_byte;
  logic        push, pop, fifo_empty, fifo_full, core_ready, core_active;

  // Bit order {bottom_l, bottom_r, top_l, top_r}.
  assign bot_code   = pair_code(sync2_q[3], sync2_q[2], CMD_BOT_L, CMD_BOT_R, CMD_BOT_STOP);
  assign top_code   = pair_code(sync2_q[1], sync2_q[0], CMD_TOP_L, CMD_TOP_R, CMD_TOP_STOP);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_byte  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop        = core_ready && !fifo_empty;
  assign busy       = core_active || !fifo_empty;

  // Two-flop synchronizer for the raw buttons.
  always_comb begin
    sync1_d = {bottom_button_l, bottom_button_r, top_button_l, top_button_r};
    sync2_d = sync1_q;
  end

  // Encoder: bottom pair has priority; a blocked change stays pending because last_* only moves on a write.
  always_comb begin
    push       = 1'b0;
    push_data  = bot_code;
    last_bot_d = last_bot_q;
    last_top_d = last_top_q;
    if (!fifo_full) begin
      if (bot_code != last_bot_q) begin
        push       = 1'b1;
        push_data  = bot_code;
        last_bot_d = bot_code;
      end else if (top_code != last_top_q) begin
        push       = 1'b1;
        push_data  = top_code;
        last_top_d = top_code;
      end
    end
  end

  // FIFO pointer and storage update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    if (push) mem_d[wr_ptr_q[AW-1:0]] = push_data;
  end

  // Registers for synchronizer, encoder history and FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      last_bot_q <= CMD_BOT_STOP;
      last_top_q <= CMD_TOP_STOP;
      mem_q      <= '{default: 8'h00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      last_bot_q <= last_bot_d;
      last_top_q <= last_top_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  uart_tx_core #(
    .DIV(DIV)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .tx_byte(head_byte),
    .valid  (!fifo_empty),
    .ready  (core_ready),
    .active (core_active),
    .tx     (RsTx)
  );

endmodule

// File: doc/paddle_cmd_tx.md
PADDLE_CMD_TX -- requirements
Module: paddle_cmd_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command byte queue depth (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  system clock; single clock domain for the whole block.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports bottom_button_l, bottom_button_r, top_button_l, top_button_r  input  1 each  raw asynchronous paddle buttons.
REQ-007 SHALL have port RsTx  output  1  UART serial line, 8N1, idle high.
REQ-008 SHALL have port busy  output  1  high while any byte is queued or being shifted.

Function
REQ-009 SHALL pass each button through a 2-flop synchronizer before any use.
REQ-010 SHALL encode the bottom pair: left only -> 0x62, right only -> 0x65, neither or both -> 0x74.
REQ-011 SHALL encode the top pair: left only -> 0x6B, right only -> 0x6D, neither or both -> 0x6C.
REQ-012 SHALL hold last_bot and last_top registers with the most recently enqueued code per pair.
REQ-013 SHALL write at most one byte per cycle: the bottom code if it differs from last_bot, else the top code if it differs from last_top.
REQ-014 SHALL update last_bot or last_top only on the cycle its byte is actually written.
REQ-015 SHALL NOT write while the FIFO is full; the pending difference persists and the current code is written once space frees, so no byte is dropped and stale intermediate codes are not sent.
REQ-016 SHALL pop the FIFO when the serializer is in IDLE and the FIFO is non-empty, leaving IDLE on that same edge.
REQ-017 SHALL run serializer states IDLE -> START -> DATA -> STOP -> IDLE, each bit lasting DIV = CLK_HZ/BAUD cycles (integer, truncated).
REQ-018 SHALL drive RsTx 0 in START, data bits LSB first in DATA (3-bit bit index), 1 in STOP and IDLE.
REQ-019 SHALL, from STOP end with the FIFO non-empty, go directly to START on the next byte with no idle bit.
REQ-020 SHALL give RsTx falling edge 4 clk edges after a button change is sampled, when idle with an empty FIFO.
REQ-021 SHALL register RsTx (no combinational path from inputs).
REQ-022 SHALL assert busy = (state != IDLE) or FIFO non-empty.

Reset
REQ-023 SHALL, on reset, force: state IDLE, RsTx 1, busy 0, FIFO empty, baud counter 0, synchronizers 0, last_bot 0x74, last_top 0x6C.
REQ-024 SHALL abort a byte in flight on reset; RsTx returns high immediately with no further bits.
REQ-025 SHALL emit no byte after reset release while all buttons are released.

Structure
REQ-026 SHALL place command byte constants (CMD_BOT_STOP 0x74, CMD_BOT_L 0x62, CMD_BOT_R 0x65, CMD_TOP_STOP 0x6C, CMD_TOP_L 0x6B, CMD_TOP_R 0x6D) and enum uart_tx_state_t in shared package pong_pkg.
REQ-027 SHALL implement the serializer as sub-module uart_tx_core (inputs: byte, valid; output: ready, tx); encoder and FIFO stay in paddle_cmd_tx.

Verification (CLK_HZ=100, BAUD=10, DIV=10)
REQ-028 SHALL check: bottom_button_l high after reset -> RsTx frame 0x62: low 10 cycles, bits 0,1,0,0,0,1,1,0, high stop 10 cycles; busy clears after stop.
REQ-029 SHALL check: bottom_button_r and top_button_l raised same cycle -> frames 0x65 then 0x6B back-to-back, no idle gap.
REQ-030 SHALL check: both bottom buttons pressed from rest -> no byte (code stays 0x74).
REQ-031 SHALL check: 6 alternating top changes during the first frame with FIFO_DEPTH 4 -> first 4 codes queued, later changes collapse to current code; no byte lost beyond that, no duplicate consecutive code per pair.
REQ-032 SHALL check: reset asserted mid-DATA -> RsTx 1 same cycle, busy 0, queue empty; after release with buttons idle, line stays high 100 cycles.
